// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int PORT0          = 0;
  localparam int PORT1          = 1;
  localparam int NUM_PORTS      = 2;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_MEM_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH = 16;

  // One requester's view of an access at the default memory geometry.
  typedef struct packed {
    logic                      req;
    logic                      we;
    logic                      lock;
    logic [DEF_MEM_WIDTH-1:0]  addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } port_req_t;

  function automatic logic other_port(input logic owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant with a bounded lock/burst; owns the owner and run-length state.
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int RUN_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  output logic [1:0]       gnt,
  output logic             dbg_owner,
  output logic [RUN_W-1:0] dbg_run
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             owner_q;
  logic             owner_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             other;
  logic             hold_lock;
  logic             grant_any;
  logic             grant_port;

  // owner resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q <= 1'b1;
      run_q   <= '0;
    end else begin
      owner_q <= owner_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    run_d   = run_q;
    if (!grant_any) begin
      run_d = '0;
    end else if (grant_port == owner_q) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
    end else begin
      owner_d = grant_port;
      run_d   = RUN_ONE;
    end
  end

  // A locked owner keeps the memory only until its run reaches MAX_BURST.
  always_comb begin
    other      = other_port(owner_q);
    hold_lock  = req[owner_q] && lock[owner_q] && (run_q < RUN_MAX);
    grant_any  = 1'b0;
    grant_port = owner_q;
    if (hold_lock) begin
      grant_any  = 1'b1;
      grant_port = owner_q;
    end else if (req[other]) begin
      grant_any  = 1'b1;
      grant_port = other;
    end else if (req[owner_q]) begin
      grant_any  = 1'b1;
      grant_port = owner_q;
    end
    gnt = 2'b00;
    if (reset && grant_any) begin
      gnt[grant_port] = 1'b1;
    end
  end

  assign dbg_owner = owner_q;
  assign dbg_run   = run_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one async-read/sync-write data memory between fetch (port 0) and load/store (port 1),
// muxing the access of the granted port and registering read data back to its requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [MEM_WIDTH-1:0]  addr0,
  input  logic [MEM_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [MEM_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int RUN_W = $clog2(MAX_BURST + 1);

  // Handshake: req is a valid that the port holds, together with we/lock/addr/wdata, until it
  // sees gnt in the same cycle; gnt is the ready and the access happens in that cycle. A read
  // then returns exactly one rvalid pulse on the following cycle, which cannot be back-pressured.
  logic [1:0]       req;
  logic [1:0]       lock;
  logic [1:0]       gnt;
  logic             arb_owner;
  logic [RUN_W-1:0] arb_run;
  logic             rd0;
  logic             rd1;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};

  arb_rr2 #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .dbg_owner (arb_owner),
    .dbg_run   (arb_run)
  );

  assign gnt0 = gnt[PORT0];
  assign gnt1 = gnt[PORT1];

  // Idle cycles park the address on port 0 so fetch sees its read data early.
  always_comb begin
    mem_addr  = addr0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_wdata = wdata0;
    end
    mem_we = (gnt0 & we0) | (gnt1 & we1);
  end

  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) begin
        rdata0 <= mem_rdata;
      end
      if (rd1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_gnt_has_req : assert property (@(posedge clk) disable iff (!reset) ((gnt & ~req) == 2'b00));
  a_run_bound : assert property (@(posedge clk) arb_run <= RUN_W'(MAX_BURST));
  a_lock_holds : assert property (@(posedge clk) disable iff (!reset)
    (req[arb_owner] && lock[arb_owner] && (arb_run < RUN_W'(MAX_BURST))) |-> gnt[arb_owner]);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven grant/mux checks plus hand sequences, with a read-return scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            n_cmp  = 0;
  int            n_fail = 0;

  typedef struct {
    port_req_t p0;
    port_req_t p1;
    logic      g0;
    logic      g1;
  } vec_t;
  vec_t      vecs[$];
  port_req_t idle_p;

  mem_arbiter #(
    .MEM_WIDTH  (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    mem[8'h10] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic port_req_t pr(input logic r, input logic w, input logic l,
                                   input logic [AW-1:0] a, input logic [DW-1:0] d);
    port_req_t p;
    p.req = r; p.we = w; p.lock = l; p.addr = a; p.wdata = d;
    return p;
  endfunction

  function automatic void add(input port_req_t p0, input port_req_t p1,
                              input logic g0, input logic g1);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.g0 = g0; v.g1 = g1;
    vecs.push_back(v);
  endfunction

  task automatic drive(input port_req_t p0, input port_req_t p1);
    req0 = p0.req; we0 = p0.we; lock0 = p0.lock; addr0 = p0.addr; wdata0 = p0.wdata;
    req1 = p1.req; we1 = p1.we; lock1 = p1.lock; addr1 = p1.addr; wdata1 = p1.wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      check("rst_gnt", {gnt1, gnt0}, 2'b00);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      check("rst_rdata", {rdata1, rdata0}, 32'h0);
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      check("sb_rvalid0", rvalid0, exp_q0.size() != 0);
      if (exp_q0.size() != 0) check("sb_rdata0", rdata0, exp_q0.pop_front());
      check("sb_rvalid1", rvalid1, exp_q1.size() != 0);
      if (exp_q1.size() != 0) check("sb_rdata1", rdata1, exp_q1.pop_front());
      check("gnt_has_req", (gnt0 & ~req0) | (gnt1 & ~req1), 1'b0);
      if (gnt0 && !we0) exp_q0.push_back(mem[addr0]);
      if (gnt1 && !we1) exp_q1.push_back(mem[addr1]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic          exp_we;
    idle_p = '0;

    // contention without lock: alternate starting with port 0
    for (int i = 0; i < 6; i++)
      add(pr(1'b1, 1'b0, 1'b0, 8'h10, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h11, 16'h0),
          (i % 2) == 0, (i % 2) == 1);
    // idle: address parks on port 0, write data zero, we ignored without req
    add(pr(1'b0, 1'b1, 1'b0, 8'h33, 16'hAAAA), pr(1'b0, 1'b1, 1'b0, 8'h44, 16'h5555), 1'b0, 1'b0);
    // locked burst on port 0 against a requesting port 1
    for (int i = 0; i < 9; i++)
      add(pr(1'b1, 1'b0, 1'b1, 8'h12, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h13, 16'h0),
          i != 4, i == 4);
    // locked port 0 alone keeps winning past MAX_BURST (writes)
    for (int i = 0; i < 5; i++)
      add(pr(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 16'(16'hC000 + i)), idle_p, 1'b1, 1'b0);
    // saturated run: port 1 takes over at once, then rotation resumes
    add(pr(1'b1, 1'b0, 1'b1, 8'h12, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h41, 16'h0), 1'b0, 1'b1);
    add(pr(1'b1, 1'b0, 1'b1, 8'h12, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h41, 16'h0), 1'b1, 1'b0);
    // locked burst on port 1 (writes) against port 0 reads
    for (int i = 0; i < 6; i++)
      add(pr(1'b1, 1'b0, 1'b0, 8'h42, 16'h0), pr(1'b1, 1'b1, 1'b1, 8'h50, 16'h5A5A),
          i == 4, i != 4);

    reset = 1'b0;
    drive(pr(1'b1, 1'b0, 1'b0, 8'h10, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h11, 16'h0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].p0, vecs[i].p1);
      @(negedge clk);
      exp_addr = vecs[i].g1 ? vecs[i].p1.addr : vecs[i].p0.addr;
      exp_wd   = vecs[i].g1 ? vecs[i].p1.wdata : (vecs[i].g0 ? vecs[i].p0.wdata : 16'h0);
      exp_we   = (vecs[i].g0 & vecs[i].p0.we) | (vecs[i].g1 & vecs[i].p1.we);
      check($sformatf("vec%0d", i), {gnt0, gnt1, mem_we, mem_addr, mem_wdata},
            {vecs[i].g0, vecs[i].g1, exp_we, exp_addr, exp_wd});
      next_cycle();
    end

    // single read of preloaded data
    drive(pr(1'b1, 1'b0, 1'b0, 8'h10, 16'h0), idle_p);
    @(negedge clk);
    check("single_gnt", {gnt0, gnt1}, 2'b10);
    next_cycle();
    drive(idle_p, idle_p);
    @(negedge clk);
    check("single_rvalid0", rvalid0, 1'b1);
    check("single_rdata0", rdata0, 16'hBEEF);
    check("single_rvalid1", rvalid1, 1'b0);
    next_cycle();

    // port 1 write, port 0 reads the same address next cycle
    drive(idle_p, pr(1'b1, 1'b1, 1'b0, 8'h20, 16'h1234));
    @(negedge clk);
    check("wr_bus", {gnt0, gnt1, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 1'b1, 8'h20, 16'h1234});
    next_cycle();
    drive(pr(1'b1, 1'b0, 1'b0, 8'h20, 16'h0), idle_p);
    @(negedge clk);
    check("raw_gnt", {gnt0, gnt1, mem_we}, 3'b100);
    check("wr_no_rvalid1", rvalid1, 1'b0);
    next_cycle();
    drive(idle_p, idle_p);
    @(negedge clk);
    check("raw_rvalid0", rvalid0, 1'b1);
    check("raw_rdata0", rdata0, 16'h1234);
    next_cycle();
    @(negedge clk);
    check("rdata0_hold", {rvalid0, rdata0}, {1'b0, 16'h1234});
    next_cycle();

    // reset while a read is in flight; owner is moved to port 0 beforehand
    drive(pr(1'b1, 1'b0, 1'b0, 8'h11, 16'h0), idle_p);
    @(negedge clk);
    check("pre_gnt0", {gnt0, gnt1}, 2'b10);
    next_cycle();
    drive(pr(1'b1, 1'b0, 1'b0, 8'h10, 16'h0), idle_p);
    @(negedge clk);
    check("inflight_gnt0", {gnt0, gnt1}, 2'b10);
    #1;
    reset = 1'b0;
    next_cycle();
    drive(idle_p, idle_p);
    @(negedge clk);
    check("rst_mid_rvalid0", rvalid0, 1'b0);
    check("rst_mid_rdata0", rdata0, 16'h0);
    next_cycle();
    reset = 1'b1;
    drive(pr(1'b1, 1'b0, 1'b0, 8'h12, 16'h0), pr(1'b1, 1'b0, 1'b0, 8'h13, 16'h0));
    @(negedge clk);
    check("post_rst_owner", {gnt0, gnt1}, 2'b10);
    next_cycle();
    drive(idle_p, idle_p);
    repeat (2) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data memory (async read, sync write) between the fetch side (port 0) and the load/store side (port 1) of the pipeline. It picks one requester per cycle with round-robin fairness, drives the memory's address, write data and write enable, and returns registered read data with a valid strobe. A bounded lock/burst mode lets one port hold the memory for back-to-back accesses without starving the other.

## Interface
- MEM_WIDTH, 8, memory address width
- DATA_WIDTH, 16, memory data width
- MAX_BURST, 4, maximum consecutive grants to a locked port while the other port is requesting (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- req0 / req1  in  1  access request, held until the port's gnt
- we0 / we1  in  1  1 = write, 0 = read, qualified by req
- lock0 / lock1  in  1  request to keep ownership for the next access
- addr0 / addr1  in  MEM_WIDTH  access address, stable while req high
- wdata0 / wdata1  in  DATA_WIDTH  write data, stable while req high
- gnt0 / gnt1  out  1  combinational; the access is performed in this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid, one cycle after a read grant
- rdata0 / rdata1  out  DATA_WIDTH  registered read data; holds last value otherwise
- mem_addr  out  MEM_WIDTH  to memory addr
- mem_wdata  out  DATA_WIDTH  to memory writeData
- mem_we  out  1  to memory writeEn
- mem_rdata  in  DATA_WIDTH  from memory readData (combinational)

## Operation
- State: owner (1 bit, last granted port), run (count of consecutive grants to owner, 0..MAX_BURST, saturating).
- Grant decision each cycle (other = !owner):
  - req[owner] && lock[owner] && run < MAX_BURST → grant owner.
  - else req[other] → grant other.
  - else req[owner] → grant owner.
  - else no grant.
- At most one gnt high per cycle; gnt never asserted without the matching req.
- State update: grant to owner → run = min(run+1, MAX_BURST); grant to other → owner = other, run = 1; no grant → run = 0, owner unchanged.
- Lock with the other port idle: owner keeps winning after MAX_BURST (run saturates); rotation happens only when the other port requests.
- Memory mux: mem_addr/mem_wdata follow the granted port; with no grant, mem_addr = addr0 and mem_wdata = 0. mem_we = gnt0&we0 | gnt1&we1.
- Read return: on a read grant to port p, rdata_p <= mem_rdata and rvalid_p <= 1 at the next edge; otherwise rvalid_p <= 0 and rdata_p holds its value.
- Write grants produce no rvalid.

## Timing
- Grant latency: 0 cycles (combinational from req and registered state); write commits at the edge ending the grant cycle.
- Read latency: rvalid/rdata one cycle after gnt.
- Read-after-write to the same address from either port in the following cycle returns the new data.
- Reset (reset = 0 at an edge): owner = 1 (port 0 wins first contention), run = 0, rvalid0/1 = 0, rdata0/1 = 0. While reset is low, gnt0/1 = 0 and mem_we = 0. An access in flight when reset is applied is dropped; its rvalid does not appear.
- Requester holds req/we/addr/wdata/lock stable from assertion until gnt; req may drop in the cycle after gnt or stay high for the next access.

## Structure
- Package mem_arb_pkg: PORT0/PORT1 index constants, default MAX_BURST, and the port request struct typedef (req, we, lock, addr, wdata).
- Sub-module arb_rr2: owner/run registers and the grant decision (inputs req[1:0], lock[1:0]; output gnt[1:0]). The muxing and read-return registers stay in mem_arbiter.

## Test plan
- Reset: hold reset = 0 for 2 cycles with req0 = req1 = 1 → gnt0/1 = 0, mem_we = 0, rvalid = 0; first edge after release grants port 0.
- Single read: preload addr 0x10 = 0xBEEF; req0 read 0x10 → gnt0 same cycle, rvalid0 = 1 and rdata0 = 0xBEEF next cycle, rvalid1 = 0.
- Contention, no lock: req0 and req1 held for 6 cycles → grants alternate 0,1,0,1,0,1.
- Locked burst, MAX_BURST = 4: lock0 = 1, req0 and req1 held → gnt0 ×4, gnt1 ×1, then gnt0 ×4 again. With req1 low the whole time → gnt0 every cycle.
- Write then read: port 1 writes 0x1234 to 0x20, then port 0 reads 0x20 in the next cycle → rdata0 = 0x1234; no rvalid1 for the write.
- Reset mid-read: read granted at cycle N, reset = 0 at edge N+1 → rvalid0 stays 0, rdata0 = 0, owner is back to its reset value.
